// File: rtl/tft_pkg.sv
// Shared timing and colour definitions for the 480x272 RGB565 TFT panel.
package tft_pkg;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned RGB_W = 16;

    // Default panel timing (clocks / lines)
    localparam int unsigned H_SYNC  = 41;
    localparam int unsigned H_BACK  = 2;
    localparam int unsigned H_VALID = 480;
    localparam int unsigned H_FRONT = 2;
    localparam int unsigned V_SYNC  = 10;
    localparam int unsigned V_BACK  = 2;
    localparam int unsigned V_VALID = 272;
    localparam int unsigned V_FRONT = 2;

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

    // Active window bounds: start inclusive, end exclusive
    localparam int unsigned H_ACT_START = H_SYNC + H_BACK;
    localparam int unsigned H_ACT_END   = H_ACT_START + H_VALID;
    localparam int unsigned V_ACT_START = V_SYNC + V_BACK;
    localparam int unsigned V_ACT_END   = V_ACT_START + V_VALID;

    localparam logic [CNT_W-1:0] PIX_INVALID = 10'h3FF;

    // RGB565 colours shared with the pixel generator
    localparam logic [RGB_W-1:0] RGB_BLACK  = 16'h0000;
    localparam logic [RGB_W-1:0] RGB_WHITE  = 16'hFFFF;
    localparam logic [RGB_W-1:0] RGB_RED    = 16'hF800;
    localparam logic [RGB_W-1:0] RGB_GREEN  = 16'h07E0;
    localparam logic [RGB_W-1:0] RGB_BLUE   = 16'h001F;
    localparam logic [RGB_W-1:0] RGB_GOLDEN = 16'hFEC0;

endpackage

// File: rtl/tft_ctrl_if.sv
// Pixel-request and panel bus of the TFT timing controller.
interface tft_ctrl_if;
    import tft_pkg::*;

    logic [CNT_W-1:0] pix_x;
    logic [CNT_W-1:0] pix_y;
    logic [RGB_W-1:0] pix_data;
    logic [RGB_W-1:0] rgb_tft;
    logic             hsync;
    logic             vsync;
    logic             tft_clk_out;
    logic             tft_de;
    logic             tft_bl;
    logic             frame_start;
    logic [7:0]       frame_cnt;

    modport master (
        input  pix_data,
        output pix_x, pix_y, rgb_tft, hsync, vsync, tft_clk_out,
               tft_de, tft_bl, frame_start, frame_cnt
    );

    modport slave (
        output pix_data,
        input  pix_x, pix_y, rgb_tft, hsync, vsync, tft_clk_out,
               tft_de, tft_bl, frame_start, frame_cnt
    );

endinterface

// File: rtl/tft_hv_cnt.sv
// Horizontal/vertical raster counters with line-end and frame-end flags.
module tft_hv_cnt #(
    parameter int unsigned H_TOT = tft_pkg::H_TOTAL,
    parameter int unsigned V_TOT = tft_pkg::V_TOTAL
) (
    input  logic                      tft_clk,
    input  logic                      sys_rst,
    output logic [tft_pkg::CNT_W-1:0] cnt_h,
    output logic [tft_pkg::CNT_W-1:0] cnt_v,
    output logic                      line_end,
    output logic                      frame_end
);
    import tft_pkg::*;

    assign line_end  = (cnt_h == CNT_W'(H_TOT - 1));
    assign frame_end = line_end && (cnt_v == CNT_W'(V_TOT - 1));

    // Pixel counter: wraps at the end of every line
    always_ff @(posedge tft_clk or posedge sys_rst) begin
        if (sys_rst)       cnt_h <= '0;
        else if (line_end) cnt_h <= '0;
        else               cnt_h <= cnt_h + 1'b1;
    end

    // Line counter: advances on line end, wraps on the same edge at frame end
    always_ff @(posedge tft_clk or posedge sys_rst) begin
        if (sys_rst)        cnt_v <= '0;
        else if (frame_end) cnt_v <= '0;
        else if (line_end)  cnt_v <= cnt_v + 1'b1;
    end

endmodule

// File: rtl/tft_ctrl.sv
// TFT timing controller: sync/DE generation, pixel requests, RGB mux, backlight.
// Optional frame_start/frame_cnt outputs built only with TFT_FRAME_CNT_EN defined.
module tft_ctrl #(
    parameter int unsigned P_H_SYNC  = tft_pkg::H_SYNC,
    parameter int unsigned P_H_BACK  = tft_pkg::H_BACK,
    parameter int unsigned P_H_VALID = tft_pkg::H_VALID,
    parameter int unsigned P_H_FRONT = tft_pkg::H_FRONT,
    parameter int unsigned P_V_SYNC  = tft_pkg::V_SYNC,
    parameter int unsigned P_V_BACK  = tft_pkg::V_BACK,
    parameter int unsigned P_V_VALID = tft_pkg::V_VALID,
    parameter int unsigned P_V_FRONT = tft_pkg::V_FRONT
) (
    input  logic       tft_clk,
    input  logic       sys_rst,
    tft_ctrl_if.master bus
);
    import tft_pkg::*;

    localparam int unsigned HT    = P_H_SYNC + P_H_BACK + P_H_VALID + P_H_FRONT;
    localparam int unsigned VT    = P_V_SYNC + P_V_BACK + P_V_VALID + P_V_FRONT;
    localparam int unsigned H_ST  = P_H_SYNC + P_H_BACK;
    localparam int unsigned H_END = H_ST + P_H_VALID;
    localparam int unsigned V_ST  = P_V_SYNC + P_V_BACK;
    localparam int unsigned V_END = V_ST + P_V_VALID;

    logic [CNT_W-1:0] cnt_h;
    logic [CNT_W-1:0] cnt_v;
    logic             line_end;
    logic             frame_end;
    logic             req_c;
    logic             hsync_q;
    logic             vsync_q;
    logic             de_q;
    logic             bl_q;
    logic             unused_line_end;

    tft_hv_cnt #(
        .H_TOT (HT),
        .V_TOT (VT)
    ) u_hv_cnt (
        .tft_clk   (tft_clk),
        .sys_rst   (sys_rst),
        .cnt_h     (cnt_h),
        .cnt_v     (cnt_v),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    // line_end is part of the counter interface but not needed for decode here
    assign unused_line_end = line_end;

    assign req_c = (cnt_h >= CNT_W'(H_ST)) && (cnt_h < CNT_W'(H_END)) &&
                   (cnt_v >= CNT_W'(V_ST)) && (cnt_v < CNT_W'(V_END));

    assign bus.pix_x       = req_c ? cnt_h - CNT_W'(H_ST) : PIX_INVALID;
    assign bus.pix_y       = req_c ? cnt_v - CNT_W'(V_ST) : PIX_INVALID;
    assign bus.tft_clk_out = tft_clk;

    // Panel controls lag the counters by one clock to line up with pix_data
    always_ff @(posedge tft_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            bl_q    <= 1'b0;
        end else begin
            hsync_q <= !(cnt_h < CNT_W'(P_H_SYNC));
            vsync_q <= !(cnt_v < CNT_W'(P_V_SYNC));
            de_q    <= req_c;
            if (frame_end) bl_q <= 1'b1;
        end
    end

    assign bus.hsync   = hsync_q;
    assign bus.vsync   = vsync_q;
    assign bus.tft_de  = de_q;
    assign bus.tft_bl  = bl_q;
    assign bus.rgb_tft = de_q ? bus.pix_data : RGB_BLACK;

`ifdef TFT_FRAME_CNT_EN
    logic       fstart_q;
    logic [7:0] fcnt_q;

    // Frame pulse one clock after the raster origin; counter follows the pulse
    always_ff @(posedge tft_clk or posedge sys_rst) begin
        if (sys_rst) begin
            fstart_q <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            fstart_q <= (cnt_h == '0) && (cnt_v == '0);
            if (fstart_q) fcnt_q <= fcnt_q + 8'd1;
        end
    end

    assign bus.frame_start = fstart_q;
    assign bus.frame_cnt   = fcnt_q;
`else
    assign bus.frame_start = 1'b0;
    assign bus.frame_cnt   = 8'd0;
`endif

endmodule

// File: tb/tb_tft_ctrl.sv
// Bench for tft_ctrl: full-size instance plus a shrunk-timing instance,
// both checked every cycle against a cycle-count based model of the raster.
module tb_tft_ctrl;

    typedef struct packed {
        longint hs; longint hb; longint hv; longint hf;
        longint vs; longint vb; longint vv; longint vf;
    } tim_t;

    typedef struct packed {
        logic [9:0]  px;
        logic [9:0]  py;
        logic [15:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
        logic        bl;
        logic        fs;
        logic [7:0]  fc;
        logic        co;
    } exp_t;

    localparam tim_t TIM_A = '{41, 2, 480, 2, 10, 2, 272, 2};
    localparam tim_t TIM_B = '{4, 2, 8, 2, 2, 1, 4, 1};
    localparam longint FT_B = 128;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [15:0] pd_a, pd_b;
    longint      na, nb;
    int          checks = 0;
    int          failures = 0;

    tft_ctrl_if bus_a();
    tft_ctrl_if bus_b();

    assign bus_a.pix_data = pd_a;
    assign bus_b.pix_data = pd_b;

    tft_ctrl u_dut_a (
        .tft_clk (clk),
        .sys_rst (rst_a),
        .bus     (bus_a.master)
    );

    tft_ctrl #(
        .P_H_SYNC (4), .P_H_BACK (2), .P_H_VALID (8), .P_H_FRONT (2),
        .P_V_SYNC (2), .P_V_BACK (1), .P_V_VALID (4), .P_V_FRONT (1)
    ) u_dut_b (
        .tft_clk (clk),
        .sys_rst (rst_b),
        .bus     (bus_b.master)
    );

    always #5 clk = ~clk;

    // Clock edges elapsed since the last reset release
    always @(posedge clk or posedge rst_a) begin
        if (rst_a) na <= 0;
        else       na <= na + 1;
    end
    always @(posedge clk or posedge rst_b) begin
        if (rst_b) nb <= 0;
        else       nb <= nb + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
        end
    endtask

    function automatic logic in_win(input longint h, input longint v, input tim_t t);
        return (h >= t.hs + t.hb) && (h < t.hs + t.hb + t.hv) &&
               (v >= t.vs + t.vb) && (v < t.vs + t.vb + t.vv);
    endfunction

    // Expected outputs after n clock edges since reset release (n=0 also covers reset)
    function automatic exp_t model(input longint n, input tim_t t, input logic [15:0] pd);
        exp_t   e;
        longint ht, vt, ft, c, h, v;
        ht = t.hs + t.hb + t.hv + t.hf;
        vt = t.vs + t.vb + t.vv + t.vf;
        ft = ht * vt;
        c  = n % ft;
        h  = c % ht;
        v  = c / ht;
        e  = '0;
        e.px = 10'h3FF;
        e.py = 10'h3FF;
        if (in_win(h, v, t)) begin
            e.px = 10'(h - (t.hs + t.hb));
            e.py = 10'(v - (t.vs + t.vb));
        end
        e.hs = 1'b1;
        e.vs = 1'b1;
        if (n > 0) begin
            c    = (n - 1) % ft;
            h    = c % ht;
            v    = c / ht;
            e.hs = (h >= t.hs);
            e.vs = (v >= t.vs);
            e.de = in_win(h, v, t);
            e.rgb = e.de ? pd : 16'h0000;
`ifdef TFT_FRAME_CNT_EN
            e.fs = (c == 0);
            if (n >= 2) e.fc = 8'((((n - 2) / ft) + 1) % 256);
`endif
        end
        e.bl = (n >= ft);
        e.co = 1'b0;
        return e;
    endfunction

    // Per-cycle compare at the falling edge, then new random pixel data
    initial begin : compare
        exp_t   act, e;
        logic   pa_hs, pa_vs, pa_de, pb_bl;
        longint hlow, vlow, dehi, last_hf;
        pd_a = 16'h0; pd_b = 16'h0;
        pa_hs = 1'b1; pa_vs = 1'b1; pa_de = 1'b0; pb_bl = 1'b0;
        hlow = 0; vlow = 0; dehi = 0; last_hf = -1;
        forever begin
            @(negedge clk);
            act = '{bus_a.pix_x, bus_a.pix_y, bus_a.rgb_tft, bus_a.hsync, bus_a.vsync,
                    bus_a.tft_de, bus_a.tft_bl, bus_a.frame_start, bus_a.frame_cnt,
                    bus_a.tft_clk_out};
            e = model(na, TIM_A, pd_a);
            chk("a.outputs", 64'(act), 64'(e));
            act = '{bus_b.pix_x, bus_b.pix_y, bus_b.rgb_tft, bus_b.hsync, bus_b.vsync,
                    bus_b.tft_de, bus_b.tft_bl, bus_b.frame_start, bus_b.frame_cnt,
                    bus_b.tft_clk_out};
            e = model(nb, TIM_B, pd_b);
            chk("b.outputs", 64'(act), 64'(e));

            // Hand-computed pins on the full-size panel
            if (rst_a || na == 0) begin
                pa_hs = 1'b1; pa_vs = 1'b1; pa_de = 1'b0;
                hlow = 0; vlow = 0; dehi = 0; last_hf = -1;
            end else begin
                if (!bus_a.hsync) hlow++;
                else if (!pa_hs) begin chk("a.hsync_low_run", 64'(hlow), 64'd41); hlow = 0; end
                if (pa_hs && !bus_a.hsync) begin
                    if (last_hf >= 0) chk("a.hsync_fall_period", 64'(na - last_hf), 64'd525);
                    last_hf = na;
                end
                if (!bus_a.vsync) vlow++;
                else if (!pa_vs) begin chk("a.vsync_low_run", 64'(vlow), 64'd5250); vlow = 0; end
                if (bus_a.tft_de) dehi++;
                else if (pa_de) begin chk("a.de_run", 64'(dehi), 64'd480); dehi = 0; end
                if (na == 6343) begin
                    chk("a.first_pix_x", 64'(bus_a.pix_x), 64'd0);
                    chk("a.first_pix_y", 64'(bus_a.pix_y), 64'd0);
                end
                if (na == 6344) begin
                    chk("a.first_de", 64'(bus_a.tft_de), 64'd1);
                    chk("a.first_rgb", 64'(bus_a.rgb_tft), 64'hFEC0);
                end
                pa_hs = bus_a.hsync; pa_vs = bus_a.vsync; pa_de = bus_a.tft_de;
            end

            // Hand-computed pins on the shrunk panel (128-clock frame)
            if (!rst_b) begin
                if (!pb_bl && bus_b.tft_bl) chk("b.bl_rise_cycle", 64'(nb), 64'(FT_B));
`ifdef TFT_FRAME_CNT_EN
                if (nb == 1)     chk("b.frame_start_first", 64'(bus_b.frame_start), 64'd1);
                if (nb == 129)   chk("b.frame_cnt_first", 64'(bus_b.frame_cnt), 64'd1);
                if (nb == 32641) chk("b.frame_cnt_255", 64'(bus_b.frame_cnt), 64'd255);
                if (nb == 32642) chk("b.frame_cnt_wrap", 64'(bus_b.frame_cnt), 64'd0);
`else
                if (nb == 1)     chk("b.frame_start_tied", 64'(bus_b.frame_start), 64'd0);
                if (nb == 129)   chk("b.frame_cnt_tied", 64'(bus_b.frame_cnt), 64'd0);
`endif
            end
            pb_bl = bus_b.tft_bl;

            pd_a = (na == 6343 && !rst_a) ? 16'hFEC0 : 16'($urandom);
            pd_b = 16'($urandom);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin : stimulus
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rst.hsync", 64'(bus_a.hsync), 64'd1);
        chk("rst.vsync", 64'(bus_a.vsync), 64'd1);
        chk("rst.de", 64'(bus_a.tft_de), 64'd0);
        chk("rst.bl", 64'(bus_a.tft_bl), 64'd0);
        chk("rst.rgb", 64'(bus_a.rgb_tft), 64'd0);
        chk("rst.pix_x", 64'(bus_a.pix_x), 64'h3FF);
        chk("rst.pix_y", 64'(bus_a.pix_y), 64'h3FF);
        @(posedge clk);
        #2;
        rst_a = 1'b0;
        rst_b = 1'b0;
        fork
            begin : seq_a
                repeat (52700) @(posedge clk);
                #1;
                chk("a.mid_pix_x", 64'(bus_a.pix_x), 64'd157);
                chk("a.mid_pix_y", 64'(bus_a.pix_y), 64'd88);
                #1;
                rst_a = 1'b1;
                #1;
                chk("a.async_de", 64'(bus_a.tft_de), 64'd0);
                chk("a.async_rgb", 64'(bus_a.rgb_tft), 64'd0);
                chk("a.async_pix_x", 64'(bus_a.pix_x), 64'h3FF);
                chk("a.async_pix_y", 64'(bus_a.pix_y), 64'h3FF);
                chk("a.async_hsync", 64'(bus_a.hsync), 64'd1);
                repeat (3) @(posedge clk);
                #2;
                rst_a = 1'b0;
                repeat (600) @(posedge clk);
                #1;
                chk("a.bl_after_rst", 64'(bus_a.tft_bl), 64'd0);
            end
            begin : seq_b
                repeat (6) begin
                    repeat ($urandom_range(20, 300)) @(posedge clk);
                    #2;
                    rst_b = 1'b1;
                    repeat ($urandom_range(1, 4)) @(posedge clk);
                    #2;
                    rst_b = 1'b0;
                end
                repeat (257 * 128 + 20) @(posedge clk);
            end
        join
        @(negedge clk);
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
